// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit -- instruction fetch stage of the Maluch core.
//
// Keeps the program counter and issues one word-addressed read at a time to
// instruction memory over a req/ack handshake. The returned word is held in
// an output register that feeds the decoder. Handles decode-side stalls and
// control-flow redirects; a fetch made stale by a redirect is discarded.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     read request (registered)
//   imem_addr    read address, stable while a request waits for its ack
//   imem_ack     read complete this cycle (ignored when imem_req=0)
//   imem_rdata   read data, valid with imem_ack
//   instr        held instruction word
//   instr_valid  instr holds an unconsumed instruction
//   instr_pc     address instr was fetched from
//   stall        decode cannot consume instr this cycle
//   redirect     one-cycle pulse: flush and resume fetching at redirect_pc
//   redirect_pc  redirect target
//
// INSTR_W must match the width of the core's instruction type.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic              consume;
  logic              out_free;
  logic              issue;
  logic              load;

  assign consume   = instr_valid & ~stall;
  assign out_free  = ~instr_valid | consume;
  assign imem_addr = req_addr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect has priority everywhere
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!redirect && out_free) state_nxt = REQ;
      REQ: begin
        if (imem_ack)      state_nxt = IDLE;
        else if (redirect) state_nxt = DROP;
      end
      DROP: if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    issue = 1'b0;
    load  = 1'b0;
    unique case (state)
      IDLE:    issue = !redirect && out_free;
      REQ:     load  = imem_ack && !redirect;
      default: ;
    endcase
  end

  // imem_req has its own flop (mirrors state_nxt != IDLE) so the pin is a
  // clean register output rather than a decode of the state bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req    <= 1'b0;
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      imem_req <= (state_nxt != IDLE);

      if (redirect)  fetch_pc <= redirect_pc;
      else if (load) fetch_pc <= req_addr + 1'b1;

      if (issue) req_addr <= fetch_pc;

      if (load) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
        instr_pc    <= req_addr;
      end else if (redirect || consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
